// File: rtl/fuzzy_pkg.sv
// Shared fuzzy-controller types and constants: Q7.0 samples, Q1.15 grades.
package fuzzy_pkg;

  typedef logic signed [7:0] q7_t;
  typedef logic [15:0]       q1_15_t;

  localparam int     FRAC_BITS = 15;
  localparam q1_15_t MU_ONE    = 16'h7FFF;
  localparam q1_15_t MU_ZERO   = 16'h0000;

  // Clamp a 24-bit unsigned quotient to the Q1.15 range [0, 1.0].
  function automatic q1_15_t sat_q15(input logic [23:0] quot);
    q1_15_t res;
    if (quot > {8'd0, MU_ONE}) begin
      res = MU_ONE;
    end else begin
      res = quot[15:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fuzzifier_dt_trap_mf.sv
// Purely combinational single trapezoid membership evaluator.
// Region priority: outside [a,d] -> 0, plateau [b,c] -> 1.0,
// rising edge a<x<b, otherwise falling edge. All differences are
// taken at 9 bits so the full Q7.0 range cannot overflow.
module trap_mf
  import fuzzy_pkg::*;
(
  input  q7_t    x,
  input  q7_t    a,
  input  q7_t    b,
  input  q7_t    c,
  input  q7_t    d,
  output q1_15_t mu
);

  logic signed [8:0] x9, a9, b9, c9, d9;
  logic signed [8:0] t;
  logic signed [8:0] dx;
  logic [23:0]       num;
  logic [23:0]       quot;

  assign x9 = {x[7], x};
  assign a9 = {a[7], a};
  assign b9 = {b[7], b};
  assign c9 = {c[7], c};
  assign d9 = {d[7], d};

  // Region selection, edge slope operands, divide and saturation.
  always_comb begin
    t    = 9'sd0;
    dx   = 9'sd1;
    num  = 24'd0;
    quot = 24'd0;
    mu   = MU_ZERO;
    if ((x9 <= a9) || (x9 >= d9)) begin
      mu = MU_ZERO;
    end else if ((x9 >= b9) && (x9 <= c9)) begin
      mu = MU_ONE;
    end else begin
      if (x9 < b9) begin
        // Rising edge (x > a already established above).
        t  = x9 - a9;
        dx = b9 - a9;
      end else begin
        // Falling edge.
        t  = d9 - x9;
        dx = d9 - c9;
      end
      if (dx == 9'sd0) begin
        dx = 9'sd1;
      end else begin
        dx = dx;
      end
      num  = {t, {FRAC_BITS{1'b0}}};
      quot = num / {15'd0, dx};
      mu   = sat_q15(quot);
    end
  end

endmodule

// File: rtl/fuzzifier_dt.sv
// Three-set (NEG/ZERO/POS) fuzzifier for the dT input with a registered
// Q1.15 output bank; one result per clock, one cycle of latency.
module fuzzifier_dt
  import fuzzy_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic signed [7:0] x,
  input  logic signed [7:0] a_neg,
  input  logic signed [7:0] b_neg,
  input  logic signed [7:0] c_neg,
  input  logic signed [7:0] d_neg,
  input  logic signed [7:0] a_zero,
  input  logic signed [7:0] b_zero,
  input  logic signed [7:0] c_zero,
  input  logic signed [7:0] d_zero,
  input  logic signed [7:0] a_pos,
  input  logic signed [7:0] b_pos,
  input  logic signed [7:0] c_pos,
  input  logic signed [7:0] d_pos,
  output logic [15:0]       mu_neg,
  output logic [15:0]       mu_zero,
  output logic [15:0]       mu_pos
);

  q1_15_t mu_neg_s, mu_zero_s, mu_pos_s;
  q1_15_t mu_neg_d, mu_zero_d, mu_pos_d;
  q1_15_t mu_neg_q, mu_zero_q, mu_pos_q;

  trap_mf u_neg (
    .x (x), .a (a_neg), .b (b_neg), .c (c_neg), .d (d_neg), .mu (mu_neg_s)
  );

  trap_mf u_zero (
    .x (x), .a (a_zero), .b (b_zero), .c (c_zero), .d (d_zero), .mu (mu_zero_s)
  );

  trap_mf u_pos (
    .x (x), .a (a_pos), .b (b_pos), .c (c_pos), .d (d_pos), .mu (mu_pos_s)
  );

  // Next-state for the output bank: capture the fresh grades every cycle.
  always_comb begin
    mu_neg_d  = mu_neg_s;
    mu_zero_d = mu_zero_s;
    mu_pos_d  = mu_pos_s;
  end

  // Output register bank, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mu_neg_q  <= MU_ZERO;
      mu_zero_q <= MU_ZERO;
      mu_pos_q  <= MU_ZERO;
    end else begin
      mu_neg_q  <= mu_neg_d;
      mu_zero_q <= mu_zero_d;
      mu_pos_q  <= mu_pos_d;
    end
  end

  assign mu_neg  = mu_neg_q;
  assign mu_zero = mu_zero_q;
  assign mu_pos  = mu_pos_q;

endmodule

// File: tb/tb_fuzzifier_dt.sv
// Directed and randomized self-checking bench for fuzzifier_dt.
module tb_fuzzifier_dt;

  logic              clk;
  logic              rst_n;
  logic signed [7:0] x;
  logic signed [7:0] a_neg, b_neg, c_neg, d_neg;
  logic signed [7:0] a_zero, b_zero, c_zero, d_zero;
  logic signed [7:0] a_pos, b_pos, c_pos, d_pos;
  logic [15:0]       mu_neg, mu_zero, mu_pos;

  int checks;
  int errors;

  fuzzifier_dt dut (
    .clk (clk), .rst_n (rst_n), .x (x),
    .a_neg (a_neg), .b_neg (b_neg), .c_neg (c_neg), .d_neg (d_neg),
    .a_zero (a_zero), .b_zero (b_zero), .c_zero (c_zero), .d_zero (d_zero),
    .a_pos (a_pos), .b_pos (b_pos), .c_pos (c_pos), .d_pos (d_pos),
    .mu_neg (mu_neg), .mu_zero (mu_zero), .mu_pos (mu_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int en, input int ez, input int ep);
    chk({tag, ".neg"},  mu_neg,  16'(en));
    chk({tag, ".zero"}, mu_zero, 16'(ez));
    chk({tag, ".pos"},  mu_pos,  16'(ep));
  endtask

  // Drive x between edges, then sample just after the capturing edge.
  task automatic step(input int xv);
    @(negedge clk);
    x = 8'(xv);
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    a_neg  = -8'sd100; b_neg  = -8'sd50; c_neg  = -8'sd30; d_neg  = -8'sd5;
    a_zero = -8'sd10;  b_zero = 8'sd0;   c_zero = 8'sd0;   d_zero = 8'sd10;
    a_pos  = 8'sd5;    b_pos  = 8'sd25;  c_pos  = 8'sd35;  d_pos  = 8'sd60;
  endtask

  // Integer reference of the priority-ordered trapezoid rule.
  function automatic int ref_mf(input int xv, input int a, input int b, input int c, input int d);
    int t, dx, q;
    if (xv <= a || xv >= d) return 0;
    if (xv >= b && xv <= c) return 32767;
    if (xv < b) begin
      t = xv - a; dx = b - a;
    end else begin
      t = d - xv; dx = d - c;
    end
    if (dx == 0) dx = 1;
    q = (t * 32768) / dx;
    return (q > 32767) ? 32767 : q;
  endfunction

  task automatic gen_sorted(output logic signed [7:0] a, output logic signed [7:0] b,
                            output logic signed [7:0] c, output logic signed [7:0] d);
    int v[4];
    int tmp;
    for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (v[j] > v[j+1]) begin
          tmp = v[j]; v[j] = v[j+1]; v[j+1] = tmp;
        end
    a = 8'(v[0]); b = 8'(v[1]); c = 8'(v[2]); d = 8'(v[3]);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    x      = 8'sd0;
    set_defaults();
    #2;
    chk3("reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    step(-128); chk3("x=-128", 0, 0, 0);
    step(127);  chk3("x=127", 0, 0, 0);
    step(-40);  chk3("x=-40", 32767, 0, 0);
    step(0);    chk3("x=0", 0, 32767, 0);
    step(-60);  chk3("x=-60", 26214, 0, 0);
    step(-5);   chk3("x=-5", 0, 16384, 0);
    step(15);   chk3("x=15", 0, 0, 16384);
    step(50);   chk3("x=50", 0, 0, 13107);

    a_neg = 8'sd0; b_neg = 8'sd0; c_neg = 8'sd0; d_neg = 8'sd0;
    step(0);    chk("degen0.neg", mu_neg, 16'd0);
    b_neg = 8'sd0; c_neg = 8'sd5; d_neg = 8'sd5;
    step(5);    chk("degen5.neg", mu_neg, 16'd0);
    set_defaults();

    // Asynchronous reset between edges.
    step(0);    chk("prerst.zero", mu_zero, 16'd32767);
    #2;
    rst_n = 1'b0;
    #1;
    chk3("asyncrst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst.zero", mu_zero, 16'd32767);

    // Randomized ordered breakpoints against the reference.
    for (int n = 0; n < 150; n++) begin
      int xv;
      @(negedge clk);
      gen_sorted(a_neg, b_neg, c_neg, d_neg);
      gen_sorted(a_zero, b_zero, c_zero, d_zero);
      gen_sorted(a_pos, b_pos, c_pos, d_pos);
      xv = int'($urandom_range(0, 255)) - 128;
      x  = 8'(xv);
      @(posedge clk);
      #1;
      chk("rnd.neg",  mu_neg,  16'(ref_mf(xv, int'(a_neg), int'(b_neg), int'(c_neg), int'(d_neg))));
      chk("rnd.zero", mu_zero, 16'(ref_mf(xv, int'(a_zero), int'(b_zero), int'(c_zero), int'(d_zero))));
      chk("rnd.pos",  mu_pos,  16'(ref_mf(xv, int'(a_pos), int'(b_pos), int'(c_pos), int'(d_pos))));
      chk("rnd.bit15", {15'd0, (mu_neg[15] | mu_zero[15] | mu_pos[15])}, 16'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fuzzifier_dt.md
# fuzzifier_dt

Three-set fuzzifier for the signed temperature-derivative input (dT) in the fuzzy controller datapath. It evaluates trapezoidal membership functions NEG, ZERO and POS over one Q7.0 sample and registers three Q1.15 membership grades in [0, 1.0]. Its outputs feed the rule-evaluation stage. All breakpoints are run-time inputs, so software or upstream logic can retune the sets without resynthesis.

## Interface
- No parameters. Widths are fixed: 8-bit Q7.0 inputs, 16-bit Q1.15 outputs.
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- x  in  8 signed  dT sample, Q7.0
- a_neg, b_neg, c_neg, d_neg  in  8 signed each  NEG trapezoid breakpoints
- a_zero, b_zero, c_zero, d_zero  in  8 signed each  ZERO trapezoid breakpoints (triangle when b = c)
- a_pos, b_pos, c_pos, d_pos  in  8 signed each  POS trapezoid breakpoints
- mu_neg, mu_zero, mu_pos  out  16 unsigned each  registered membership grades, Q1.15, 0x7FFF = 1.0

## Operation
Each set evaluates f(x, a, b, c, d) independently. Conditions are tested in this priority order:
1. x ≤ a or x ≥ d → 0x0000. This covers degenerate sets: a = x = b gives 0, and c = d = x gives 0.
2. b ≤ x ≤ c → 0x7FFF.
3. a < x < b (rising edge):
   - t = x − a and dx = b − a, both computed as 9-bit signed.
   - If dx = 0, force dx = 1.
   - mu = (unsigned(t) << 15) / unsigned(dx), using a 24-bit unsigned numerator and truncating division.
4. Any other case (falling edge):
   - t = d − x and dx = d − c, both 9-bit signed.
   - If dx = 0, force dx = 1.
   - mu = (unsigned(t) << 15) / unsigned(dx).

Further rules:
- Saturate any result above 0x7FFF to 0x7FFF. Bit 15 of every output is therefore always 0.
- Breakpoint ordering a ≤ b ≤ c ≤ d is not checked. Out-of-order parameters still produce the priority-order result above, never X.
- All differences are sign-extended to 9 bits, so no intermediate overflows across the full −128..127 range.

## Timing
- Outputs are registered, with 1-cycle latency. x and all 12 breakpoints are sampled together on the same rising clk edge, and mu_* reflect them right after that edge.
- There is no handshake and no enable. A new result is produced every cycle (throughput 1/clk).
- Division is combinational and completes within one cycle; no multicycle or pipelined divider.
- rst_n low clears mu_neg, mu_zero and mu_pos to 0x0000 immediately, independent of clk, including mid-stream.
- The first valid result appears on the first rising edge after rst_n is released.
- Parameter changes take effect on the next edge; nothing is latched beyond that one cycle.

## Structure
- Shared fuzzy package holds:
  - Q1.15 constants MU_ONE = 16'h7FFF and MU_ZERO = 16'h0000.
  - Q7.0 and Q1.15 typedefs.
  - FRAC_BITS = 15.
- One natural sub-module, trap_mf: a purely combinational single-trapezoid evaluator containing the region compare, divide and saturation. It is instantiated three times.
- The top level only wraps the three trap_mf instances and adds the output register bank with async reset.

## Test plan
All cases use default sets NEG (−100, −50, −30, −5), ZERO (−10, 0, 0, 10), POS (5, 25, 35, 60), unless stated otherwise. Each check is made one cycle after applying x.
- Extremes: x = −128 and x = 127 → all three outputs 0.
- Plateau and triangle apex:
  - x = −40 → mu_neg = 32767, others 0.
  - x = 0 → mu_zero = 32767, others 0.
- Rising edges:
  - x = −60 → mu_neg = 26214.
  - x = −5 → mu_zero = 16384, mu_neg = 0, mu_pos = 0.
  - x = 15 → mu_pos = 16384.
- Falling edge with truncation: x = 50 → mu_pos = 13107 (exact value 13107.2).
- Degenerate set: NEG = (0, 0, 0, 0), x = 0 → mu_neg = 0. NEG = (0, 0, 5, 5), x = 5 → mu_neg = 0.
- Reset:
  - Drive x = 0 and confirm mu_zero = 32767.
  - Assert rst_n between edges → all outputs 0 before the next edge.
  - Release rst_n → mu_zero = 32767 again one edge later.
  - Also run randomized ordered breakpoints against a reference model and check that bit 15 of every output is never set.
